sequence_generator: RTL

Serial bit-stream transmitter that produces the single-bit input stream consumed by the sequence detector. A parallel frame of up to WIDTH bits is loaded through a valid/ready handshake and shifted out MSB-first, one bit per clock. Optional repeat mode recirculates the frame with a programmable idle gap between frames. Sits between the stimulus/control logic and the detector's serial input `x`.

---
 rtl/seqgen_pkg.sv | 13 +
 rtl/sequence_generator.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seqgen_pkg.sv
// rtl/seqgen_pkg.sv - shared state encoding and default sizes for the serial sequence generator
package seqgen_pkg;

    localparam int SEQGEN_WIDTH = 24;
    localparam int SEQGEN_GAP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } seqgen_state_t;

endpackage

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - MSB-first serial frame transmitter with optional recirculation and idle gap
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   load_valid/load_ready frame handshake (ready only while idle)
//   load_data, load_len   frame bits (MSB first) and length (0 or >WIDTH means WIDTH)
//   repeat_en, gap_len    recirculate flag and idle cycles between frames, sampled at load
//   stop                  end recirculation after the current frame / end a gap at once
//   x, x_valid            registered serial bit and its qualifier (x is 0 when not valid)
//   busy, done            not-idle decode and one-cycle pulse on return to idle
module sequence_generator
    import seqgen_pkg::*;
#(
    parameter int WIDTH = SEQGEN_WIDTH,
    parameter int GAP_W = SEQGEN_GAP_W,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_len,
    input  logic             repeat_en,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             stop,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    seqgen_state_t    state, state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] frame;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] frame_len;
    logic [CNT_W-1:0] eff_len;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_q;
    logic             rep_q;
    logic             start;
    logic             reload;
    logic             enter_gap;
    logic             finish;

    // Out-of-range lengths send the full register.
    always_comb begin
        eff_len = load_len;
        if (load_len == '0 || load_len > CNT_W'(WIDTH))
            eff_len = CNT_W'(WIDTH);
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        reload     = 1'b0;
        enter_gap  = 1'b0;
        finish     = 1'b0;
        load_ready = (state == IDLE);
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (load_valid) begin
                    start      = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                // A stop seen on the last bit already cancels the recirculation.
                if (bit_cnt == '0) begin
                    if (rep_q && !stop) begin
                        if (gap_q == '0) begin
                            reload = 1'b1;
                        end else begin
                            enter_gap  = 1'b1;
                            state_next = GAP;
                        end
                    end else begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (gap_cnt == '0) begin
                    reload     = 1'b1;
                    state_next = SEND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            frame     <= '0;
            bit_cnt   <= '0;
            frame_len <= '0;
            gap_cnt   <= '0;
            gap_q     <= '0;
            rep_q     <= 1'b0;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done    <= finish;
            x_valid <= (state_next == SEND);

            if (start) begin
                frame     <= load_data;
                frame_len <= eff_len;
                rep_q     <= repeat_en;
                gap_q     <= gap_len;
            end else if (stop && state != IDLE) begin
                rep_q <= 1'b0;
            end

            // x is registered, so the bit presented next cycle is loaded here.
            if (start) begin
                x       <= load_data[WIDTH-1];
                shreg   <= {load_data[WIDTH-2:0], 1'b0};
                bit_cnt <= eff_len - CNT_W'(1);
            end else if (reload) begin
                x       <= frame[WIDTH-1];
                shreg   <= {frame[WIDTH-2:0], 1'b0};
                bit_cnt <= frame_len - CNT_W'(1);
            end else if (state == SEND && state_next == SEND) begin
                x       <= shreg[WIDTH-1];
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt - CNT_W'(1);
            end else begin
                x <= 1'b0;
            end

            if (enter_gap)
                gap_cnt <= gap_q - GAP_W'(1);
            else if (state == GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

endmodule
